// File: rtl/hazard_control_unit_pkg.sv
// Shared types and defaults for the hazard control unit.
// Holds the FSM state encoding, the default MDU timeout, and the load-use detector.
package hazard_control_unit_pkg;

  // Controller states: IDLE = 1'b0, MDU_WAIT = 1'b1.
  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StMduWait = 1'b1
  } hcu_state_e;

  localparam int unsigned MduTimeoutDefault = 63;
  // Wide enough for the largest legal timeout (63).
  localparam int unsigned WaitCntW = 6;

  // EX-stage load whose destination is read by the ID-stage instruction.
  function automatic logic load_use_hazard(
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       uses_rs1,
    input logic       uses_rs2,
    input logic [4:0] rd,
    input logic       mem_read,
    input logic       reg_write_en
  );
    logic match;
    match = (uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2));
    return mem_read && reg_write_en && (rd != 5'd0) && match;
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Stall and flush performance counters, wrapping modulo 2^32.
// Present only when HAZARD_PERF_CNT_EN is defined.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_inc,
  input  logic        flush_inc,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Count cycles with a PC stall and cycles with an IF/ID flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_inc) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`endif

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stalls, branch flushes, and multi-cycle MDU
// sequencing with a timeout abort.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int unsigned MDU_TIMEOUT = MduTimeoutDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  if_id_r_rs1_addr,
  input  logic [4:0]  if_id_r_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  id_ex_r_rd_addr,
  input  logic        id_ex_r_mem_read,
  input  logic        id_ex_r_reg_write_en,
  input  logic        id_ex_r_is_mdu,
  input  logic        mdu_done,
  input  logic        ex_branch_taken,
  output logic        mdu_start,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mdu_timeout,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam logic [WaitCntW-1:0] TimeoutVal = WaitCntW'(MDU_TIMEOUT);

  hcu_state_e          state_q, state_d;
  logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;
  logic                load_use;

  assign load_use = load_use_hazard(if_id_r_rs1_addr, if_id_r_rs2_addr, id_uses_rs1,
                                    id_uses_rs2, id_ex_r_rd_addr, id_ex_r_mem_read,
                                    id_ex_r_reg_write_en);

  // Next-state and pipeline control decode.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
    mdu_start    = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    case (state_q)
      StIdle: begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (id_ex_r_is_mdu) begin
          mdu_start   = 1'b1;
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
          wait_cnt_d  = '0;
          state_d     = StMduWait;
        end else if (load_use) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end
      StMduWait: begin
        // Branches and load-use are frozen behind the MDU; only done/timeout matter.
        if (mdu_done) begin
          state_d = StIdle;
        end else if (wait_cnt_q == TimeoutVal) begin
          id_ex_flush = 1'b1;
          timeout_d   = 1'b1;
          state_d     = StIdle;
        end else begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
          wait_cnt_d  = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mdu_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counters u_perf_counters (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_inc (pc_stall),
    .flush_inc (if_id_flush),
    .stall_cnt (perf_stall_cnt),
    .flush_cnt (perf_flush_cnt)
  );
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit with MDU_TIMEOUT = 5.
// Expected control vectors are queued when stimulus is driven and compared on the
// following falling edge.
module tb_hazard_control_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic        u1, u2, mr, we, is_mdu, done, br;
  logic        mdu_start, pc_stall, if_id_stall, id_ex_stall, id_ex_bubble;
  logic        if_id_flush, id_ex_flush, mdu_timeout;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  logic [6:0]  ctl;

  // {pc_stall, if_id_stall, id_ex_stall, id_ex_bubble, if_id_flush, id_ex_flush, mdu_start}
  localparam logic [6:0] CNone   = 7'b000_0000;
  localparam logic [6:0] CLu     = 7'b110_1000;
  localparam logic [6:0] CStart  = 7'b111_0001;
  localparam logic [6:0] CStall  = 7'b111_0000;
  localparam logic [6:0] CBranch = 7'b000_0110;
  localparam logic [6:0] CAbort  = 7'b000_0010;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_stall = 0;
  int          exp_flush = 0;
  logic [6:0]  exp_q[$];
  string       tag_q[$];
  logic [6:0]  mon_exp;
  string       mon_tag;

  hazard_control_unit #(
    .MDU_TIMEOUT (5)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .if_id_r_rs1_addr     (rs1),
    .if_id_r_rs2_addr     (rs2),
    .id_uses_rs1          (u1),
    .id_uses_rs2          (u2),
    .id_ex_r_rd_addr      (rd),
    .id_ex_r_mem_read     (mr),
    .id_ex_r_reg_write_en (we),
    .id_ex_r_is_mdu       (is_mdu),
    .mdu_done             (done),
    .ex_branch_taken      (br),
    .mdu_start            (mdu_start),
    .pc_stall             (pc_stall),
    .if_id_stall          (if_id_stall),
    .id_ex_stall          (id_ex_stall),
    .id_ex_bubble         (id_ex_bubble),
    .if_id_flush          (if_id_flush),
    .id_ex_flush          (id_ex_flush),
    .mdu_timeout          (mdu_timeout),
    .perf_stall_cnt       (perf_stall_cnt),
    .perf_flush_cnt       (perf_flush_cnt)
  );

  assign ctl = {pc_stall, if_id_stall, id_ex_stall, id_ex_bubble, if_id_flush, id_ex_flush,
                mdu_start};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge and queue its expectation.
  task automatic cyc(input logic [4:0] a1, input logic [4:0] a2, input logic x1,
                     input logic x2, input logic [4:0] d, input logic m, input logic w,
                     input logic mdu, input logic dn, input logic b,
                     input logic [6:0] exp, input string tag);
    @(posedge clk);
    #1;
    rs1 = a1; rs2 = a2; u1 = x1; u2 = x2; rd = d; mr = m; we = w;
    is_mdu = mdu; done = dn; br = b;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic idle_cyc(input logic [6:0] exp, input string tag);
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp, tag);
  endtask

  task automatic mdu_cyc(input logic dn, input logic [6:0] exp, input string tag);
    // Concurrent load-use and branch are presented to show they are ignored in MDU_WAIT.
    cyc(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, dn, exp == CStall, exp, tag);
  endtask

  // Scoreboard: compare the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      check(mon_tag, {25'd0, ctl}, {25'd0, mon_exp});
      if (mon_exp[6]) exp_stall++;
      if (mon_exp[2]) exp_flush++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0;
    u1 = 0; u2 = 0; mr = 0; we = 0; is_mdu = 0; done = 0; br = 0;
    #2;
    check("rst_ctl", {25'd0, ctl}, 32'd0);
    check("rst_timeout", {31'd0, mdu_timeout}, 32'd0);
    check("rst_perf_stall", perf_stall_cnt, 32'd0);
    #20 rst_n = 1'b1;

    // Load-use detection.
    idle_cyc(CNone, "post_rst_idle");
    cyc(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CLu, "lu_rs1");
    idle_cyc(CNone, "lu_one_cycle");
    cyc(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CNone, "lu_x0");
    cyc(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CLu, "lu_rs2");
    cyc(5'd3, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CNone, "lu_rs2_unused");
    cyc(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CNone, "no_mem_read");
    cyc(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CNone, "no_write_en");
    cyc(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, CBranch, "branch_lu");
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, CBranch, "branch_mdu");
    idle_cyc(CNone, "idle_after_branch");

    // MDU op finishing on the fourth cycle after launch.
    mdu_cyc(1'b0, CStart, "mdu_start");
    for (int i = 0; i < 3; i++) mdu_cyc(1'b0, CStall, "mdu_wait");
    mdu_cyc(1'b1, CNone, "mdu_done");
    // Back-to-back op relaunches the cycle after done.
    mdu_cyc(1'b0, CStart, "mdu_b2b_start");
    mdu_cyc(1'b1, CNone, "mdu_b2b_done");
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CNone, "done_in_idle");

    // Done arriving exactly at the timeout count wins over the abort.
    mdu_cyc(1'b0, CStart, "race_start");
    for (int i = 0; i < 5; i++) mdu_cyc(1'b0, CStall, "race_wait");
    mdu_cyc(1'b1, CNone, "race_done");
    idle_cyc(CNone, "race_idle");
    check("race_no_timeout", {31'd0, mdu_timeout}, 32'd0);

    // No done: five stall cycles in MDU_WAIT, then abort.
    mdu_cyc(1'b0, CStart, "to_start");
    for (int i = 0; i < 5; i++) mdu_cyc(1'b0, CStall, "to_wait");
    mdu_cyc(1'b0, CAbort, "to_abort");
    idle_cyc(CNone, "to_idle");
    check("timeout_set", {31'd0, mdu_timeout}, 32'd1);
    idle_cyc(CNone, "to_idle2");
    idle_cyc(CNone, "to_idle3");
    check("timeout_sticky", {31'd0, mdu_timeout}, 32'd1);

    // Perf counters against the expectations consumed so far.
    @(negedge clk);
    #1;
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall", perf_stall_cnt, 32'(exp_stall));
    check("perf_flush", perf_flush_cnt, 32'(exp_flush));
`else
    check("perf_stall_tied", perf_stall_cnt, 32'd0);
    check("perf_flush_tied", perf_flush_cnt, 32'd0);
`endif

    // Asynchronous reset in the middle of MDU_WAIT.
    mdu_cyc(1'b0, CStart, "rst_mid_start");
    mdu_cyc(1'b0, CStall, "rst_mid_wait");
    @(negedge clk);
    #1;
    is_mdu = 0; rs1 = '0; rd = '0; u1 = 0; mr = 0; we = 0; br = 0;
    #1;
    check("pre_rst_wait", {25'd0, ctl}, {25'd0, CStall});
    rst_n = 1'b0;
    #1;
    check("async_rst_ctl", {25'd0, ctl}, 32'd0);
    check("async_rst_timeout", {31'd0, mdu_timeout}, 32'd0);
    check("async_rst_perf", perf_stall_cnt, 32'd0);
    exp_stall = 0;
    exp_flush = 0;
    #13 rst_n = 1'b1;
    idle_cyc(CNone, "post_rst_first");
    cyc(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CLu, "post_rst_lu");
    // Ten load-use stalls for the perf stall counter.
    for (int i = 0; i < 9; i++)
      cyc(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CLu, "lu_burst");
    idle_cyc(CNone, "final_idle");
    @(negedge clk);
    #1;
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_10", perf_stall_cnt, 32'd10);
`else
    check("perf_stall_10_tied", perf_stall_cnt, 32'd0);
`endif
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
